// File: rtl/add_accum.sv
// -----------------------------------------------------------------------------
// add_accum
//
// Streaming unsigned accumulator placed downstream of the datapath adder.
// It takes COUNT consecutive WIDTH-bit operands over a valid/ready handshake,
// sums them, and presents the total on a registered output that has its own
// valid/ready handshake. With COUNT == 1 it acts as a one-stage registered
// pipe: every operand becomes a total.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   COUNT  operands summed into each result (>= 1)
//
// Ports
//   Clk        in   rising-edge clock
//   Rst_n      in   asynchronous, active-low reset
//   clear      in   synchronous abort of a partial accumulation
//   in_valid   in   in_data is valid
//   in_ready   out  block accepts in_data this cycle (combinational)
//   in_data    in   operand (unsigned)
//   out_valid  out  out_data holds a completed total
//   out_ready  in   consumer takes out_data this cycle
//   out_data   out  completed total (unsigned)
//   busy       out  partial accumulation in progress (cnt != 0)
//
// Build option
//   ADD_ACCUM_SATURATE_EN  when defined, a carry out of bit WIDTH-1 clamps the
//                          running sum to all-ones. When undefined, the sum
//                          wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module add_accum #(
    parameter int WIDTH = 64,
    parameter int COUNT = 4
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    // Operand counter is at least one bit wide, even when COUNT == 1.
    localparam int               CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             in_fire;
    logic             out_fire;
    logic             last_operand;
    logic [WIDTH-1:0] next_sum;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // Input is refused during clear, and also while a finished total is
    // waiting on a stalled consumer. Accepting input then could complete a new
    // total with nowhere to put it.
    assign in_ready     = !clear && (!out_valid || out_ready);
    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign last_operand = (cnt == CNT_LAST);
    assign busy         = (cnt != '0);

    // -------------------------------------------------------------------------
    // Next running sum
    // -------------------------------------------------------------------------
    // The first operand of a total replaces the accumulator rather than adding
    // to it. acc is already zero at that point, but selecting in_data directly
    // keeps a stale acc out of the sum.
`ifdef ADD_ACCUM_SATURATE_EN
    logic [WIDTH:0] sum_wide;

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path; a missing default here would infer a latch.
    always_comb begin
        sum_wide = '0;
        if (cnt == '0) begin
            sum_wide = {1'b0, in_data};
        end else begin
            sum_wide = {1'b0, acc} + {1'b0, in_data};
        end
        // Once the sum clamps to all-ones, any later non-zero operand carries
        // out again and adding zero leaves it unchanged. The clamp therefore
        // persists to the end of the total without extra state.
        next_sum = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
    end
`else
    // Wrapping mode drops bit WIDTH, so a WIDTH-bit add gives the same result.
    always_comb begin
        next_sum = '0;
        if (cnt == '0) begin
            next_sum = in_data;
        end else begin
            next_sum = acc + in_data;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Accumulator and operand counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together on the edge, and no block sees another block's
    // new value within the same cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            // clear also holds in_ready low, so in_fire cannot occur here.
            acc <= '0;
            cnt <= '0;
        end else if (in_fire) begin
            if (last_operand) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= next_sum;
                cnt <= cnt + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result register
    // -------------------------------------------------------------------------
    // A new total takes priority over retiring the old one. When the consumer
    // takes a total in the same cycle that the next one completes, out_valid
    // stays high and out_data advances. clear never touches this register, so
    // a pending total is still delivered.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_fire && last_operand) begin
            out_valid <= 1'b1;
            out_data  <= next_sum;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // The counter wraps only through completion or clear.
    cnt_in_range : assert property (
        @(posedge Clk) disable iff (!Rst_n) cnt <= CNT_LAST
    );

    // A stalled total holds its value until the consumer takes it.
    out_held_under_stall : assert property (
        @(posedge Clk) disable iff (!Rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data))
    );
`endif

endmodule

// File: tb/tb_add_accum.sv
// -----------------------------------------------------------------------------
// tb_add_accum
//
// Bench for add_accum. It drives two instances: a 64-bit, COUNT 4 unit for
// the main scenarios and an 8-bit, COUNT 2 unit for overflow behaviour.
// Expected totals are computed by hand and queued when a test starts. One
// monitor per instance pops and compares a queued total each time the DUT
// hands one off.
// -----------------------------------------------------------------------------
module tb_add_accum;

    logic        Clk;
    logic        Rst_n;

    // 64-bit, COUNT 4 instance
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    // 8-bit, COUNT 2 instance
    logic        s_clear;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic        s_busy;

    int          checks;
    int          errors;

    logic [63:0] sb_q[$];
    logic [63:0] s_sb_q[$];

    add_accum #(.WIDTH(64), .COUNT(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    add_accum #(.WIDTH(8), .COUNT(2)) dut_small (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .clear     (s_clear),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .busy      (s_busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Hard stop in case a process hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Offer one operand to the wide instance and return at posedge+1 of the
    // handshake.
    task automatic send(input logic [63:0] d);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        forever begin
            @(negedge Clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", {63'd0, in_ready}, 64'd1);
                break;
            end
        end
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [7:0] d);
        int n;
        n          = 0;
        s_in_data  = d;
        s_in_valid = 1'b1;
        forever begin
            @(negedge Clk);
            if (s_in_ready) break;
            n++;
            if (n > 50) begin
                check("s_send_timeout", {63'd0, s_in_ready}, 64'd1);
                break;
            end
        end
        @(posedge Clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        s_clear     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;

        // Scoreboard monitors: each output handshake (sampled on the falling
        // edge) must match the oldest queued total.
        fork
            forever begin
                @(negedge Clk);
                if (Rst_n && out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL total_unexpected: actual %0d required none", out_data);
                    end else begin
                        check("total", out_data, sb_q.pop_front());
                    end
                end
            end
            forever begin
                @(negedge Clk);
                if (Rst_n && s_out_valid && s_out_ready) begin
                    if (s_sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL s_total_unexpected: actual %0d required none", s_out_data);
                    end else begin
                        check("s_total", {56'd0, s_out_data}, s_sb_q.pop_front());
                    end
                end
            end
        join_none

        // ---- Reset / idle --------------------------------------------------
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(negedge Clk);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge Clk);
        #1;

        // ---- Basic total: 1+2+3+4 = 10 -------------------------------------
        sb_q.push_back(64'd10);
        send(64'd1);
        check("basic_busy1", {63'd0, busy}, 64'd1);
        send(64'd2);
        check("basic_busy2", {63'd0, busy}, 64'd1);
        send(64'd3);
        check("basic_busy3", {63'd0, busy}, 64'd1);
        send(64'd4);
        check("basic_valid_rise", {63'd0, out_valid}, 64'd1);
        check("basic_data", out_data, 64'd10);
        check("basic_busy4", {63'd0, busy}, 64'd0);
        @(posedge Clk);
        #1;
        check("basic_valid_pulse", {63'd0, out_valid}, 64'd0);

        // ---- Backpressure: total 100 held for 5 cycles ---------------------
        out_ready = 1'b0;
        sb_q.push_back(64'd100);
        send(64'd10);
        send(64'd20);
        send(64'd30);
        send(64'd40);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_out_data", out_data, 64'd100);
            @(posedge Clk);
            #1;
        end
        // Take the total and offer 7 in the same cycle.
        sb_q.push_back(64'd10);           // 7 + 1 + 1 + 1
        out_ready = 1'b1;
        in_data   = 64'd7;
        in_valid  = 1'b1;
        @(negedge Clk);
        check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        check("bp_release_busy", {63'd0, busy}, 64'd1);
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        send(64'd1);
        send(64'd1);
        send(64'd1);
        check("bp_second_total", out_data, 64'd10);

        // ---- Clear: 5, 6, clear (offering 99), then 1,1,1,1 -> only 4 ------
        sb_q.push_back(64'd4);
        send(64'd5);
        send(64'd6);
        check("clr_busy_before", {63'd0, busy}, 64'd1);
        clear    = 1'b1;
        in_data  = 64'd99;
        in_valid = 1'b1;
        @(negedge Clk);
        check("clr_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge Clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_busy_after", {63'd0, busy}, 64'd0);
        send(64'd1);
        send(64'd1);
        send(64'd1);
        send(64'd1);
        check("clr_total", out_data, 64'd4);

        // ---- Async reset mid-accumulation ----------------------------------
        @(posedge Clk);
        #1;
        send(64'd1);
        send(64'd1);
        check("ar_busy_before", {63'd0, busy}, 64'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("ar_busy_in_reset", {63'd0, busy}, 64'd0);
        check("ar_out_valid_in_reset", {63'd0, out_valid}, 64'd0);
        #1;
        Rst_n = 1'b1;
        sb_q.push_back(64'd4);
        send(64'd1);
        send(64'd1);
        send(64'd1);
        send(64'd1);
        check("ar_total", out_data, 64'd4);

        // ---- Overflow on the 8-bit, COUNT 2 instance -----------------------
`ifdef ADD_ACCUM_SATURATE_EN
        s_sb_q.push_back(64'd255);        // 200 + 100 clamps
        s_sb_q.push_back(64'd255);        // 255 + 1 clamps
`else
        s_sb_q.push_back(64'd44);         // 300 mod 256
        s_sb_q.push_back(64'd0);          // 256 mod 256
`endif
        s_sb_q.push_back(64'd127);        // 100 + 27, no carry
        s_send(8'd200);
        check("ovf_busy", {63'd0, s_busy}, 64'd1);
        s_send(8'd100);
        s_send(8'd255);
        s_send(8'd1);
        s_send(8'd100);
        s_send(8'd27);

        // ---- Drain and confirm every expected total arrived ----------------
        repeat (5) @(posedge Clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'd0);
        check("s_sb_drain", 64'(s_sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
